// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register: hold/shift/rotate/ASR/load/clear with serial I/O at both ends.
// Define SHREG_BURST_EN to compile in the burst engine (start/count repeat with busy/done).
module shift_reg_univ #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OpHold  = 3'b000;
  localparam logic [2:0] OpShl   = 3'b001;
  localparam logic [2:0] OpShr   = 3'b010;
  localparam logic [2:0] OpRol   = 3'b011;
  localparam logic [2:0] OpRor   = 3'b100;
  localparam logic [2:0] OpAsr   = 3'b101;
  localparam logic [2:0] OpLoad  = 3'b110;
  localparam logic [2:0] OpClear = 3'b111;

  if (WIDTH < 2) begin : g_width_check
    $error("shift_reg_univ: WIDTH must be at least 2");
  end

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       opc,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] res;
    unique case (opc)
      OpHold:  res = cur;
      OpShl:   res = {cur[WIDTH-2:0], sr};
      OpShr:   res = {sl, cur[WIDTH-1:1]};
      OpRol:   res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OpRor:   res = {cur[0], cur[WIDTH-1:1]};
      OpAsr:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      OpLoad:  res = ld;
      OpClear: res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] q_q, q_d;

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];

`ifdef SHREG_BURST_EN

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       bop_q, bop_d;
  logic             done_q, done_d;

  // A latched HOLD/LOAD/CLEAR only marks time: the burst never loads or clears.
  function automatic logic [WIDTH-1:0] burst_op(
    input logic [2:0]       opc,
    input logic [WIDTH-1:0] cur,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] res;
    if (opc == OpHold || opc == OpLoad || opc == OpClear) begin
      res = cur;
    end else begin
      res = apply_op(opc, cur, '0, sl, sr);
    end
    return res;
  endfunction

  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    rem_d   = rem_q;
    bop_d   = bop_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bop_d = op;
          rem_d = count;
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end else if (en) begin
          q_d = apply_op(op, q_q, data, sin_l, sin_r);
        end
      end
      StRun: begin
        if (en) begin
          q_d   = burst_op(bop_q, q_q, sin_l, sin_r);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      state_q <= StIdle;
      rem_q   <= '0;
      bop_q   <= OpHold;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      bop_q   <= bop_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;

  // done is only ever raised on the edge that returns to (or stays in) IDLE.
  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);
  a_run_rem_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
                                      busy |-> (rem_q != '0));

`else

  logic unused_burst_inputs;
  assign unused_burst_inputs = ^{start, count};

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = apply_op(op, q_q, data, sin_l, sin_r);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign busy = 1'b0;
  assign done = 1'b0;

`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ: stimulus pushes expected state per cycle, a monitor checks.
module tb_shift_reg_univ;

  localparam logic [2:0] OpHold  = 3'b000;
  localparam logic [2:0] OpShl   = 3'b001;
  localparam logic [2:0] OpShr   = 3'b010;
  localparam logic [2:0] OpRol   = 3'b011;
  localparam logic [2:0] OpRor   = 3'b100;
  localparam logic [2:0] OpAsr   = 3'b101;
  localparam logic [2:0] OpLoad  = 3'b110;
  localparam logic [2:0] OpClear = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] op;
  logic [7:0] data;
  logic       sin_l;
  logic       sin_r;
  logic       start;
  logic [4:0] count;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  shift_reg_univ #(.WIDTH(8), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .op     (op),
    .data   (data),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .start  (start),
    .count  (count),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per clock once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.name, ".q"}, q, e.q);
        chk({e.name, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
        chk({e.name, ".done"}, {7'd0, done}, {7'd0, e.done});
        chk({e.name, ".sout_l"}, {7'd0, sout_l}, {7'd0, e.q[7]});
        chk({e.name, ".sout_r"}, {7'd0, sout_r}, {7'd0, e.q[0]});
      end
    end
  end

  // Drive one cycle of inputs (at a negedge) and queue the state expected after the next edge.
  task automatic cyc(input string nm, input logic e, input logic [2:0] o, input logic [7:0] d,
                     input logic st, input logic [4:0] cnt,
                     input logic [7:0] eq, input logic eb, input logic ed);
    exp_t x;
    en    = e;
    op    = o;
    data  = d;
    start = st;
    count = cnt;
    x.name = nm;
    x.q    = eq;
    x.busy = eb;
    x.done = ed;
    sb.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    op    = OpHold;
    data  = 8'h00;
    sin_l = 1'b0;
    sin_r = 1'b0;
    start = 1'b0;
    count = 5'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    cyc("reset",    1'b0, OpHold,  8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
    cyc("load_a5",  1'b1, OpLoad,  8'hA5, 1'b0, 5'd0, 8'hA5, 1'b0, 1'b0);
    cyc("en0_hold", 1'b0, OpShl,   8'h00, 1'b0, 5'd0, 8'hA5, 1'b0, 1'b0);
    cyc("load_81",  1'b1, OpLoad,  8'h81, 1'b0, 5'd0, 8'h81, 1'b0, 1'b0);
    cyc("rol",      1'b1, OpRol,   8'h00, 1'b0, 5'd0, 8'h03, 1'b0, 1'b0);
    cyc("load_81b", 1'b1, OpLoad,  8'h81, 1'b0, 5'd0, 8'h81, 1'b0, 1'b0);
    cyc("ror",      1'b1, OpRor,   8'h00, 1'b0, 5'd0, 8'hC0, 1'b0, 1'b0);
    cyc("load_81c", 1'b1, OpLoad,  8'h81, 1'b0, 5'd0, 8'h81, 1'b0, 1'b0);
    cyc("asr",      1'b1, OpAsr,   8'h00, 1'b0, 5'd0, 8'hC0, 1'b0, 1'b0);
    cyc("load_81d", 1'b1, OpLoad,  8'h81, 1'b0, 5'd0, 8'h81, 1'b0, 1'b0);
    cyc("shr_sl0",  1'b1, OpShr,   8'h00, 1'b0, 5'd0, 8'h40, 1'b0, 1'b0);
    sin_r = 1'b1;
    cyc("shl_sr1",  1'b1, OpShl,   8'h00, 1'b0, 5'd0, 8'h81, 1'b0, 1'b0);
    sin_r = 1'b0;
    sin_l = 1'b1;
    cyc("shr_sl1",  1'b1, OpShr,   8'h00, 1'b0, 5'd0, 8'hC0, 1'b0, 1'b0);
    sin_l = 1'b0;
    cyc("clear",    1'b1, OpClear, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0);

`ifdef SHREG_BURST_EN
    // Burst SHL x3, start/op held active while busy must be ignored.
    cyc("b_load01", 1'b1, OpLoad,  8'h01, 1'b0, 5'd0, 8'h01, 1'b0, 1'b0);
    cyc("b_t0",     1'b1, OpShl,   8'h00, 1'b1, 5'd3, 8'h01, 1'b1, 1'b0);
    cyc("b_t1",     1'b1, OpLoad,  8'hFF, 1'b1, 5'd7, 8'h02, 1'b1, 1'b0);
    cyc("b_t2",     1'b1, OpLoad,  8'hFF, 1'b1, 5'd7, 8'h04, 1'b1, 1'b0);
    cyc("b_t3",     1'b1, OpLoad,  8'hFF, 1'b1, 5'd7, 8'h08, 1'b0, 1'b1);
    cyc("b_after",  1'b0, OpHold,  8'h00, 1'b0, 5'd0, 8'h08, 1'b0, 1'b0);

    // Same burst with a two-cycle stall.
    cyc("s_load01", 1'b1, OpLoad,  8'h01, 1'b0, 5'd0, 8'h01, 1'b0, 1'b0);
    cyc("s_t0",     1'b1, OpShl,   8'h00, 1'b1, 5'd3, 8'h01, 1'b1, 1'b0);
    cyc("s_t1",     1'b1, OpHold,  8'h00, 1'b0, 5'd0, 8'h02, 1'b1, 1'b0);
    cyc("s_stall1", 1'b0, OpHold,  8'h00, 1'b0, 5'd0, 8'h02, 1'b1, 1'b0);
    cyc("s_stall2", 1'b0, OpHold,  8'h00, 1'b0, 5'd0, 8'h02, 1'b1, 1'b0);
    cyc("s_t2",     1'b1, OpHold,  8'h00, 1'b0, 5'd0, 8'h04, 1'b1, 1'b0);
    cyc("s_t3",     1'b1, OpHold,  8'h00, 1'b0, 5'd0, 8'h08, 1'b0, 1'b1);

    // Back-to-back: ROR x2, next start accepted on the edge where done is high.
    cyc("bb_t0",    1'b1, OpRor,   8'h00, 1'b1, 5'd2, 8'h08, 1'b1, 1'b0);
    cyc("bb_t1",    1'b1, OpHold,  8'h00, 1'b0, 5'd0, 8'h04, 1'b1, 1'b0);
    cyc("bb_t2",    1'b1, OpHold,  8'h00, 1'b0, 5'd0, 8'h02, 1'b0, 1'b1);
    cyc("bb2_t0",   1'b1, OpRol,   8'h00, 1'b1, 5'd1, 8'h02, 1'b1, 1'b0);
    cyc("bb2_t1",   1'b1, OpHold,  8'h00, 1'b0, 5'd0, 8'h04, 1'b0, 1'b1);
    cyc("bb2_idle", 1'b0, OpHold,  8'h00, 1'b0, 5'd0, 8'h04, 1'b0, 1'b0);

    // Latched CLEAR behaves as HOLD for count cycles.
    cyc("clr_t0",   1'b1, OpClear, 8'h00, 1'b1, 5'd2, 8'h04, 1'b1, 1'b0);
    cyc("clr_t1",   1'b1, OpHold,  8'h00, 1'b0, 5'd0, 8'h04, 1'b1, 1'b0);
    cyc("clr_t2",   1'b1, OpHold,  8'h00, 1'b0, 5'd0, 8'h04, 1'b0, 1'b1);

    // Zero count: no busy, done the next cycle.
    cyc("z_t0",     1'b1, OpShl,   8'h00, 1'b1, 5'd0, 8'h04, 1'b0, 1'b1);
    cyc("z_idle",   1'b0, OpHold,  8'h00, 1'b0, 5'd0, 8'h04, 1'b0, 1'b0);

    // Asynchronous reset after one shift of a burst.
    cyc("r_load01", 1'b1, OpLoad,  8'h01, 1'b0, 5'd0, 8'h01, 1'b0, 1'b0);
    cyc("r_t0",     1'b1, OpShl,   8'h00, 1'b1, 5'd3, 8'h01, 1'b1, 1'b0);
    cyc("r_t1",     1'b1, OpHold,  8'h00, 1'b0, 5'd0, 8'h02, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.q", q, 8'h00);
    chk("async_rst.busy", {7'd0, busy}, 8'h00);
    chk("async_rst.done", {7'd0, done}, 8'h00);
    begin
      exp_t x;
      x.name = "rst_held";
      x.q    = 8'h00;
      x.busy = 1'b0;
      x.done = 1'b0;
      sb.push_back(x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst1", 1'b1, OpHold, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
    cyc("post_rst2", 1'b1, OpHold, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
`else
    // Without the burst engine, start/count are ignored and ops apply directly.
    cyc("nb_load",  1'b1, OpLoad,  8'h3C, 1'b1, 5'd3, 8'h3C, 1'b0, 1'b0);
    cyc("nb_rol",   1'b1, OpRol,   8'h00, 1'b1, 5'd3, 8'h78, 1'b0, 1'b0);
    cyc("nb_idle",  1'b0, OpHold,  8'h00, 1'b1, 5'd0, 8'h78, 1'b0, 1'b0);
    cyc("nb_asr",   1'b1, OpAsr,   8'h00, 1'b0, 5'd0, 8'h3C, 1'b0, 1'b0);
`endif

    begin
      int budget = 0;
      while (sb.size() != 0 && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL drain: %0d entries left, 0 required", sb.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
